ber_checker_ds: RTL and testbench

//  Receive-side stage fed directly by the FIR filter output (oversampled S(NBT_IN,NBT_IN-1)).

---
 rtl/ber_checker_ds.sv | 193 +++++++++++++++++++
 tb/tb_ber_checker_ds.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_checker_ds.sv
// Decimating slicer with PRBS latency search and BER counting.
// Sweeps a reference delay line until a clean window locks, then counts bits and errors.
module ber_checker_ds #(
  parameter int NBT_IN    = 8,
  parameter int OS_FACTOR = 4,
  parameter int MAX_LAT   = 64,
  parameter int WINDOW    = 256,
  parameter int LOSS_THR  = 16,
  parameter int NB_CNT    = 32,
  localparam int PW  = $clog2(OS_FACTOR),
  localparam int LW  = $clog2(MAX_LAT),
  localparam int WCW = $clog2(WINDOW),
  localparam int WEW = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [NBT_IN-1:0] i_os_data,
  input  logic [PW-1:0]     i_phase,
  input  logic              i_ref_bit,
  input  logic              i_clear,
  output logic              o_sym_bit,
  output logic              o_sym_valid,
  output logic              o_locked,
  output logic [LW-1:0]     o_latency,
  output logic [NB_CNT-1:0] o_bit_count,
  output logic [NB_CNT-1:0] o_err_count
);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ph_cnt_q, ph_cnt_d;
  logic [PW-1:0]       phase_prev_q;
  logic [MAX_LAT-1:0]  dl_q, dl_d;
  logic [LW-1:0]       lat_q, lat_d;
  logic [WCW-1:0]      win_cnt_q, win_cnt_d;
  logic [WEW-1:0]      win_err_q, win_err_d;
  logic                sym_bit_q, sym_bit_d;
  logic                sym_valid_q, sym_valid_d;
  logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;

  logic                strobe_s;
  logic                slice_s;
  logic                err_s;
  logic                phase_chg_s;
  logic                close_s;
  logic [WEW-1:0]      win_err_tot_s;
  logic                unused_data_s;

  function automatic logic [LW-1:0] next_lat(input logic [LW-1:0] lat);
    if (lat == LW'(MAX_LAT - 1)) begin
      return '0;
    end else begin
      return lat + LW'(1'b1);
    end
  endfunction

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] cnt, input logic inc);
    if (inc && (cnt != '1)) begin
      return cnt + NB_CNT'(1'b1);
    end else begin
      return cnt;
    end
  endfunction

  assign strobe_s      = i_en & (ph_cnt_q == i_phase);
  assign slice_s       = i_os_data[NBT_IN-1];
  // The error uses the delay line as it stood before this symbol's reference shifts in.
  assign err_s         = slice_s ^ dl_q[lat_q];
  assign phase_chg_s   = (i_phase != phase_prev_q);
  assign win_err_tot_s = win_err_q + {{(WEW-1){1'b0}}, err_s};
  assign close_s       = strobe_s & ~phase_chg_s & (win_cnt_q == WCW'(WINDOW - 1));
  assign unused_data_s = ^i_os_data[NBT_IN-2:0];

  always_comb begin
    ph_cnt_d    = '0;
    dl_d        = dl_q;
    sym_bit_d   = sym_bit_q;
    sym_valid_d = strobe_s;
    if (i_en && (ph_cnt_q != PW'(OS_FACTOR - 1))) begin
      ph_cnt_d = ph_cnt_q + PW'(1'b1);
    end else begin
      ph_cnt_d = '0;
    end
    if (strobe_s) begin
      dl_d      = {dl_q[MAX_LAT-2:0], i_ref_bit};
      sym_bit_d = slice_s;
    end else begin
      dl_d      = dl_q;
      sym_bit_d = sym_bit_q;
    end
  end

  always_comb begin
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    if (phase_chg_s || close_s) begin
      win_cnt_d = '0;
      win_err_d = '0;
    end else if (strobe_s) begin
      win_cnt_d = win_cnt_q + WCW'(1'b1);
      win_err_d = win_err_tot_s;
    end else begin
      win_cnt_d = win_cnt_q;
      win_err_d = win_err_q;
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      ST_SEARCH: begin
        if (close_s && (win_err_tot_s == '0)) begin
          state_d = ST_LOCKED;
        end else if (close_s) begin
          lat_d = next_lat(lat_q);
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_LOCKED: begin
        if (close_s && (win_err_tot_s > WEW'(LOSS_THR))) begin
          state_d = ST_SEARCH;
          lat_d   = next_lat(lat_q);
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        lat_d   = '0;
      end
    endcase
  end

  // A clear beats a same-cycle increment.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (i_clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else if (strobe_s && (state_q == ST_LOCKED)) begin
      bit_cnt_d = sat_inc(bit_cnt_q, 1'b1);
      err_cnt_d = sat_inc(err_cnt_q, err_s);
    end else begin
      bit_cnt_d = bit_cnt_q;
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_SEARCH;
      ph_cnt_q     <= '0;
      phase_prev_q <= '0;
      dl_q         <= '0;
      lat_q        <= '0;
      win_cnt_q    <= '0;
      win_err_q    <= '0;
      sym_bit_q    <= 1'b0;
      sym_valid_q  <= 1'b0;
      bit_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ph_cnt_q     <= ph_cnt_d;
      phase_prev_q <= i_phase;
      dl_q         <= dl_d;
      lat_q        <= lat_d;
      win_cnt_q    <= win_cnt_d;
      win_err_q    <= win_err_d;
      sym_bit_q    <= sym_bit_d;
      sym_valid_q  <= sym_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_sym_bit   = sym_bit_q;
  assign o_sym_valid = sym_valid_q;
  assign o_locked    = (state_q == ST_LOCKED);
  assign o_latency   = lat_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_checker_ds.sv
// Bench for ber_checker_ds: slicer vector table, PRBS lock/loss sequences and a
// randomized run compared cycle by cycle against a queue-based reference model.
module tb_ber_checker_ds;
  localparam int OSF  = 4;
  localparam int MAXL = 16;
  localparam int WIN  = 64;
  localparam int THR  = 16;
  localparam int NBC  = 8;
  localparam int CMAX = (1 << NBC) - 1;

  logic clk = 1'b0;
  logic i_reset = 1'b0;
  logic i_en, i_ref_bit, i_clear;
  logic [7:0] i_os_data;
  logic [1:0] i_phase;
  logic o_sym_bit, o_sym_valid, o_locked;
  logic [3:0] o_latency;
  logic [NBC-1:0] o_bit_count, o_err_count;

  ber_checker_ds #(.NBT_IN(8), .OS_FACTOR(OSF), .MAX_LAT(MAXL), .WINDOW(WIN),
                   .LOSS_THR(THR), .NB_CNT(NBC)) dut (
    .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_os_data(i_os_data),
    .i_phase(i_phase), .i_ref_bit(i_ref_bit), .i_clear(i_clear),
    .o_sym_bit(o_sym_bit), .o_sym_valid(o_sym_valid), .o_locked(o_locked),
    .o_latency(o_latency), .o_bit_count(o_bit_count), .o_err_count(o_err_count));

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  // Reference model state: history of strobed reference bits, newest first.
  int m_ph, m_prev_phase, m_lat, m_wcnt, m_werr, m_bitc, m_errc;
  bit m_locked, m_symb, m_symv;
  bit m_hist[$];

  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      m_ph = 0; m_prev_phase = 0; m_lat = 0; m_wcnt = 0; m_werr = 0;
      m_bitc = 0; m_errc = 0; m_locked = 0; m_symb = 0; m_symv = 0;
      m_hist.delete();
      for (int i = 0; i < MAXL; i++) m_hist.push_back(1'b0);
    end else begin
      bit stb, b, e, chg, was_locked;
      int tot;
      stb = i_en && (m_ph == int'(i_phase));
      chg = (int'(i_phase) != m_prev_phase);
      b = i_os_data[7];
      e = b ^ m_hist[m_lat];
      was_locked = m_locked;
      m_symv = stb;
      if (stb) begin
        m_symb = b;
        m_hist.push_front(i_ref_bit);
        void'(m_hist.pop_back());
      end
      if (chg) begin
        m_wcnt = 0; m_werr = 0;
      end else if (stb) begin
        tot = m_werr + int'(e);
        if (m_wcnt == WIN - 1) begin
          if (!m_locked && tot == 0) m_locked = 1;
          else if (!m_locked || tot > THR) begin
            m_locked = 0;
            m_lat = (m_lat + 1) % MAXL;
          end
          m_wcnt = 0; m_werr = 0;
        end else begin
          m_wcnt++; m_werr = tot;
        end
      end
      if (i_clear) begin
        m_bitc = 0; m_errc = 0;
      end else if (stb && was_locked) begin
        m_bitc = (m_bitc + 1 > CMAX) ? CMAX : m_bitc + 1;
        m_errc = (m_errc + int'(e) > CMAX) ? CMAX : m_errc + int'(e);
      end
      m_ph = i_en ? (m_ph + 1) % OSF : 0;
      m_prev_phase = int'(i_phase);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      nchk++;
      if (o_sym_valid !== m_symv || o_sym_bit !== m_symb || o_locked !== m_locked ||
          o_latency !== 4'(m_lat) || o_bit_count !== 8'(m_bitc) || o_err_count !== 8'(m_errc)) begin
        nerr++;
        if (nerr <= 20)
          $display("FAIL model_cmp t=%0t got v=%0b b=%0b lk=%0b lat=%0d bc=%0d ec=%0d want v=%0b b=%0b lk=%0b lat=%0d bc=%0d ec=%0d",
                   $time, o_sym_valid, o_sym_bit, o_locked, o_latency, o_bit_count, o_err_count,
                   m_symv, m_symb, m_locked, m_lat, m_bitc, m_errc);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus state: PRBS9 reference, transmitted history, pending bit flips.
  logic [8:0] lfsr;
  bit tx[$];
  int n_stb, flip_budget, gap_mode;

  task automatic drive();
    bit fb, b;
    i_clear = 1'b0;
    case (gap_mode)
      0: i_en = 1'b1;
      1: i_en = ($urandom_range(0, 5) != 0);
      default: i_en = 1'b0;
    endcase
    i_os_data = 8'($urandom_range(0, 127));
    i_ref_bit = 1'($urandom_range(0, 1));
    if (i_en && m_ph == int'(i_phase)) begin
      fb = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], fb};
      i_ref_bit = fb;
      tx.push_front(fb);
      if (tx.size() > 32) void'(tx.pop_back());
      n_stb++;
    end
    if (i_en && m_ph == 2) begin
      b = (tx.size() > 11) ? tx[11] : 1'b0;
      if (flip_budget > 0) begin
        b = ~b;
        flip_budget--;
      end
      i_os_data = b ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
    end
  endtask

  task automatic cyc();
    drive();
    @(posedge clk); #1;
  endtask

  task automatic run_syms(input int n);
    int target;
    target = n_stb + n;
    while (n_stb < target) cyc();
  endtask

  task automatic do_reset();
    i_en = 1'b0; i_clear = 1'b0; i_os_data = 8'h00; i_ref_bit = 1'b0;
    i_reset = 1'b1;
    #1;
    check("rst_valid", o_sym_valid, 0);
    check("rst_bit", o_sym_bit, 0);
    check("rst_locked", o_locked, 0);
    check("rst_latency", o_latency, 0);
    check("rst_bitcnt", o_bit_count, 0);
    check("rst_errcnt", o_err_count, 0);
    lfsr = 9'h1FF; tx.delete(); n_stb = 0; flip_budget = 0;
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic wait_lock();
    int n;
    n = 0;
    while (o_locked !== 1'b1 && n < 20 * WIN * OSF) begin
      cyc();
      n++;
    end
    check("lock_reached", o_locked, 1);
    check("lock_symbols", n_stb, 11 * WIN);
    check("lock_latency", o_latency, 10);
    check("lock_errcnt", o_err_count, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       exp;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [NBC-1:0] bc_save, ec_save;
    tbl[0] = '{8'h00, 1'b0}; tbl[1] = '{8'h7F, 1'b0}; tbl[2] = '{8'hFF, 1'b1};
    tbl[3] = '{8'h80, 1'b1}; tbl[4] = '{8'h40, 1'b0}; tbl[5] = '{8'hC0, 1'b1};
    gap_mode = 0;
    i_phase = 2'd2;
    #2;
    do_reset();
    chk_on = 1'b1;

    // Slicer vectors: sign bit decides the symbol, valid is a single-cycle pulse.
    for (int i = 0; i < 6; i++) begin
      while (m_ph != 2) cyc();
      drive();
      i_os_data = tbl[i].data;
      @(posedge clk); #1;
      check("slice_valid", o_sym_valid, 1);
      check("slice_bit", o_sym_bit, tbl[i].exp);
      cyc();
      check("valid_pulse", o_sym_valid, 0);
    end

    // Lock acquisition on phase 2.
    do_reset();
    wait_lock();

    // Saturation and clear on a strobe cycle.
    run_syms(300);
    check("sat_bitcnt", o_bit_count, CMAX);
    check("sat_errcnt", o_err_count, 0);
    check("sat_locked", o_locked, 1);
    while (m_ph != 2) cyc();
    drive();
    i_clear = 1'b1;
    @(posedge clk); #1;
    check("clear_bitcnt", o_bit_count, 0);
    check("clear_errcnt", o_err_count, 0);

    // Enable gap: nothing moves.
    run_syms(3);
    bc_save = o_bit_count; ec_save = o_err_count;
    gap_mode = 2;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("gap_novalid", o_sym_valid, 0);
    end
    gap_mode = 0;
    check("gap_bitcnt", o_bit_count, bc_save);
    check("gap_errcnt", o_err_count, ec_save);
    check("gap_locked", o_locked, 1);

    // Five errors in one window keep lock.
    while (n_stb % WIN != 0) cyc();
    i_clear = 1'b1;
    @(posedge clk); #1;
    flip_budget = 5;
    run_syms(WIN);
    check("flip5_locked", o_locked, 1);
    check("flip5_errcnt", o_err_count, 5);

    // Asynchronous reset while locked with nonzero counts.
    do_reset();
    wait_lock();
    flip_budget = 20;
    run_syms(WIN);
    check("flip20_locked", o_locked, 0);
    check("flip20_latency", o_latency, 11);
    check("flip20_errcnt", o_err_count, 20);

    // Wrong phase never locks; latency wraps after MAXL windows.
    i_phase = 2'd0;
    do_reset();
    run_syms((MAXL - 1) * WIN);
    check("wrap_lat_max", o_latency, MAXL - 1);
    check("wrap_unlocked_a", o_locked, 0);
    run_syms(WIN);
    check("wrap_lat_zero", o_latency, 0);
    check("wrap_unlocked_b", o_locked, 0);

    // Randomized run: enable gaps, phase changes, clears, flips.
    i_phase = 2'd2;
    do_reset();
    gap_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) i_phase = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 299) == 0) i_phase = 2'd2;
      if ($urandom_range(0, 499) == 0) flip_budget = $urandom_range(1, 30);
      drive();
      if ($urandom_range(0, 99) == 0) i_clear = 1'b1;
      @(posedge clk); #1;
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
